// File: rtl/read_logic.sv
// Read side of a synchronous FIFO: pop control, read pointer, occupancy and status flags.
// Define FIFO_ERROR_FLAG_EN to build the sticky underflow/overflow flag.
module read_logic #(
  parameter int MEM_SIZE  = 4,
  parameter int WORD_SIZE = 6,
  parameter int PTR_L     = 3,
  parameter int AE_THRESH = 1,
  parameter int AF_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_rd,
  input  logic                 fifo_wr,
  input  logic                 push,
  input  logic [WORD_SIZE-1:0] mem_data,
  output logic [PTR_L-1:0]     rd_ptr,
  output logic                 pop,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic                 fifo_error
);

  localparam logic [PTR_L:0] FULL_CNT = (PTR_L+1)'(MEM_SIZE);
  localparam logic [PTR_L:0] AE_CNT   = (PTR_L+1)'(AE_THRESH);
  localparam logic [PTR_L:0] AF_CNT   = (PTR_L+1)'(AF_THRESH);
  localparam logic [PTR_L-1:0] LAST   = PTR_L'(MEM_SIZE-1);

  logic [PTR_L:0] count;

  // flags decode the registered count only
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == FULL_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign almost_full  = (count >= AF_CNT);

  assign pop = !reset && fifo_rd && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= pop;
      if (pop) begin
        data_out <= mem_data;
        rd_ptr   <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      // a push that lands on a full FIFO without a pop is dropped
      if (push && !pop && !fifo_full)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

`ifdef FIFO_ERROR_FLAG_EN
  logic err;

  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if ((fifo_rd && fifo_empty) ||
             (fifo_wr && fifo_full && !fifo_rd))
      err <= 1'b1;
  end

  assign fifo_error = err;
`else
  logic unused_wr;

  assign unused_wr  = fifo_wr;
  assign fifo_error = 1'b0;
`endif

endmodule

// File: tb/tb_read_logic.sv
// Scoreboard bench for read_logic: a small memory/occupancy model
// queues expected read data when a pop is driven and checks it on valid_out.
module tb_read_logic;

`ifdef FIFO_ERROR_FLAG_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_rd;
  logic       fifo_wr;
  logic       push;
  logic [5:0] mem_data;
  logic [2:0] rd_ptr;
  logic       pop;
  logic [5:0] data_out;
  logic       valid_out;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_empty;
  logic       almost_full;
  logic       fifo_error;

  read_logic dut (
    .clk(clk),
    .reset(reset),
    .fifo_rd(fifo_rd),
    .fifo_wr(fifo_wr),
    .push(push),
    .mem_data(mem_data),
    .rd_ptr(rd_ptr),
    .pop(pop),
    .data_out(data_out),
    .valid_out(valid_out),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .almost_empty(almost_empty),
    .almost_full(almost_full),
    .fifo_error(fifo_error)
  );

  always #5 clk = ~clk;

  logic [5:0] mem [4];
  assign mem_data = mem[rd_ptr[1:0]];

  int         checks = 0;
  int         failures = 0;
  logic [5:0] q[$];
  logic [1:0] m_ptr = 2'd0;
  logic [1:0] m_wp = 2'd0;
  int         m_count = 0;
  logic       m_err = 1'b0;
  logic       pop_seen;
  logic       pop_exp;

  // one clock of stimulus; updates the model, pushes expected read data
  task automatic tick(input logic rd, input logic wr, input logic ps,
                      input logic rs, input logic [5:0] wd);
    logic wen;
    fifo_rd = rd;
    fifo_wr = wr;
    push    = ps;
    reset   = rs;
    #1;
    pop_exp  = !rs && rd && (m_count != 0);
    pop_seen = pop;
    wen = !rs && ps && (m_count < 4 || pop_exp);
    if (pop_exp) q.push_back(mem[m_ptr]);
    @(posedge clk);
    #1;
    if (wen) begin
      mem[m_wp] = wd;
      m_wp = m_wp + 2'd1;
    end
    if (rs) begin
      m_ptr = 2'd0;
      m_wp = 2'd0;
      m_count = 0;
      m_err = 1'b0;
      q.delete();
    end else begin
      if (ERR_EN && ((rd && m_count == 0) || (wr && m_count == 4 && !rd)))
        m_err = 1'b1;
      if (pop_exp) m_ptr = m_ptr + 2'd1;
      if (wen && !pop_exp) m_count++;
      else if (pop_exp && !ps) m_count--;
    end
    fifo_rd = 1'b0;
    fifo_wr = 1'b0;
    push    = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic test_reset;
    tick(0, 0, 0, 1, 6'h00);
    tick(0, 0, 0, 1, 6'h00);
    tick(0, 0, 0, 0, 6'h00);
    checks++;
    if (rd_ptr !== 3'd0) begin
      failures++; $display("FAIL reset_rd_ptr got=%0d exp=0", rd_ptr);
    end
    checks++;
    if ({fifo_empty, almost_empty, fifo_full, almost_full} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=1100",
               {fifo_empty, almost_empty, fifo_full, almost_full});
    end
    checks++;
    if (valid_out !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", valid_out);
    end
    checks++;
    if (fifo_error !== 1'b0) begin
      failures++; $display("FAIL reset_error got=%b exp=0", fifo_error);
    end
    checks++;
    if (data_out !== 6'h00) begin
      failures++; $display("FAIL reset_data got=%h exp=00", data_out);
    end
  endtask

  task automatic test_fill_drain;
    logic [5:0] vals [4];
    logic [5:0] e;
    vals = '{6'h0A, 6'h15, 6'h2C, 6'h3F};
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1, 0, vals[i]);
      checks++;
      if (fifo_full !== (i == 3) || almost_full !== (i >= 2) ||
          almost_empty !== (i == 0) || fifo_empty !== 1'b0) begin
        failures++;
        $display("FAIL fill_flags[%0d] got=%b%b%b%b exp=%b%b%b0", i,
                 fifo_full, almost_full, almost_empty, fifo_empty,
                 i == 3, i >= 2, i == 0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0, 0, 6'h00);
      checks++;
      if (pop_seen !== 1'b1 || valid_out !== 1'b1) begin
        failures++;
        $display("FAIL drain_pop_valid[%0d] got=%b%b exp=11", i, pop_seen, valid_out);
      end
      checks++;
      e = (q.size() != 0) ? q.pop_front() : 6'hxx;
      if (data_out !== vals[i] || data_out !== e) begin
        failures++;
        $display("FAIL drain_data[%0d] got=%h exp=%h", i, data_out, vals[i]);
      end
    end
    checks++;
    if (fifo_empty !== 1'b1 || rd_ptr !== 3'd0) begin
      failures++;
      $display("FAIL drain_final got=empty%b ptr%0d exp=empty1 ptr0", fifo_empty, rd_ptr);
    end
  endtask

  task automatic test_full_simul;
    logic [5:0] e;
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 6'(6'h20 + i));
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 1, 0, 6'(6'h30 + i));
      checks++;
      if (pop_seen !== 1'b1 || fifo_full !== 1'b1 || rd_ptr !== 3'(i + 1)) begin
        failures++;
        $display("FAIL simul[%0d] got=pop%b full%b ptr%0d exp=pop1 full1 ptr%0d",
                 i, pop_seen, fifo_full, rd_ptr, i + 1);
      end
      checks++;
      e = (q.size() != 0) ? q.pop_front() : 6'hxx;
      if (valid_out !== 1'b1 || data_out !== e || data_out !== 6'(6'h20 + i)) begin
        failures++;
        $display("FAIL simul_data[%0d] got=%b/%h exp=1/%h", i, valid_out, data_out, 6'(6'h20 + i));
      end
    end
    // remaining order: 0x23 then the three entries written during the overlap
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0, 0, 6'h00);
      checks++;
      e = (q.size() != 0) ? q.pop_front() : 6'hxx;
      if (valid_out !== 1'b1 || data_out !== e) begin
        failures++;
        $display("FAIL simul_drain[%0d] got=%b/%h exp=1/%h", i, valid_out, data_out, e);
      end
    end
    checks++;
    if (fifo_empty !== 1'b1 || rd_ptr !== 3'd3) begin
      failures++;
      $display("FAIL simul_final got=empty%b ptr%0d exp=empty1 ptr3", fifo_empty, rd_ptr);
    end
  endtask

  task automatic test_underflow;
    logic [2:0] p0;
    p0 = rd_ptr;
    tick(1, 0, 0, 0, 6'h00);
    checks++;
    if (pop_seen !== 1'b0 || rd_ptr !== p0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL underflow got=pop%b ptr%0d valid%b exp=pop0 ptr%0d valid0",
               pop_seen, rd_ptr, valid_out, p0);
    end
    checks++;
    if (fifo_error !== ERR_EN || fifo_error !== m_err) begin
      failures++; $display("FAIL underflow_err got=%b exp=%b", fifo_error, ERR_EN);
    end
    tick(0, 0, 0, 0, 6'h00);
    tick(0, 0, 0, 0, 6'h00);
    checks++;
    if (fifo_error !== ERR_EN) begin
      failures++; $display("FAIL underflow_sticky got=%b exp=%b", fifo_error, ERR_EN);
    end
    tick(0, 0, 0, 1, 6'h00);
    checks++;
    if (fifo_error !== 1'b0 || rd_ptr !== 3'd0) begin
      failures++;
      $display("FAIL underflow_clear got=err%b ptr%0d exp=err0 ptr0", fifo_error, rd_ptr);
    end
  endtask

  task automatic test_overflow;
    logic [5:0] e;
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 6'(6'h10 + i));
    checks++;
    if (fifo_error !== 1'b0) begin
      failures++; $display("FAIL pre_overflow_err got=%b exp=0", fifo_error);
    end
    tick(0, 1, 1, 0, 6'h3E);
    checks++;
    if (fifo_full !== 1'b1 || fifo_error !== ERR_EN) begin
      failures++;
      $display("FAIL overflow got=full%b err%b exp=full1 err%b", fifo_full, fifo_error, ERR_EN);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0, 0, 6'h00);
      checks++;
      e = (q.size() != 0) ? q.pop_front() : 6'hxx;
      if (valid_out !== 1'b1 || data_out !== e || data_out !== 6'(6'h10 + i)) begin
        failures++;
        $display("FAIL overflow_drain[%0d] got=%b/%h exp=1/%h", i, valid_out, data_out, 6'(6'h10 + i));
      end
    end
    checks++;
    if (fifo_empty !== 1'b1) begin
      failures++; $display("FAIL overflow_final_empty got=%b exp=1", fifo_empty);
    end
    tick(0, 0, 0, 1, 6'h00);
  endtask

  task automatic test_mid_reset;
    logic [5:0] e;
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 6'(6'h01 + i));
    tick(1, 0, 0, 0, 6'h00);
    tick(1, 0, 0, 0, 6'h00);
    q.delete();
    tick(0, 0, 1, 0, 6'h04);
    tick(0, 0, 1, 0, 6'h05);
    checks++;
    if (rd_ptr !== 3'd2 || almost_full !== 1'b1 || fifo_full !== 1'b0) begin
      failures++;
      $display("FAIL mid_setup got=ptr%0d af%b full%b exp=ptr2 af1 full0", rd_ptr, almost_full, fifo_full);
    end
    tick(1, 0, 0, 1, 6'h00);
    checks++;
    if (pop_seen !== 1'b0) begin
      failures++; $display("FAIL mid_reset_pop got=%b exp=0", pop_seen);
    end
    checks++;
    if (rd_ptr !== 3'd0 || valid_out !== 1'b0 || fifo_empty !== 1'b1 || data_out !== 6'h00) begin
      failures++;
      $display("FAIL mid_reset_state got=ptr%0d valid%b empty%b data%h exp=ptr0 valid0 empty1 data00",
               rd_ptr, valid_out, fifo_empty, data_out);
    end
    tick(0, 0, 1, 0, 6'h2A);
    tick(1, 0, 0, 0, 6'h00);
    checks++;
    e = (q.size() != 0) ? q.pop_front() : 6'hxx;
    if (valid_out !== 1'b1 || data_out !== 6'h2A || data_out !== e) begin
      failures++;
      $display("FAIL post_reset_pop got=%b/%h exp=1/2a", valid_out, data_out);
    end
    tick(0, 0, 0, 0, 6'h00);
    checks++;
    if (valid_out !== 1'b0 || data_out !== 6'h2A || rd_ptr !== 3'd1) begin
      failures++;
      $display("FAIL idle_hold got=%b/%h ptr%0d exp=0/2a ptr1", valid_out, data_out, rd_ptr);
    end
  endtask

  initial begin
    reset = 1'b1;
    fifo_rd = 1'b0;
    fifo_wr = 1'b0;
    push = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 6'h00;
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_underflow();
    test_overflow();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
